fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of decode in the RV32I core.
- Owns the fetch PC, issues word requests to the synchronous instruction memory, and buffers returned instructions with their PCs in a small prefetch queue.
- Presents instructions to decode over a valid/ready handshake.
- Accepts redirects from execute/writeback (branch, JAL, JALR), which flush all queued and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- DEPTH, 2, prefetch queue entries; legal values are powers of two, 2 to 8.

Ports:
- clk  input  1  core clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- imem_req  output  1  fetch request this cycle
- imem_addr  output  32  word-aligned fetch address, valid when imem_req=1
- imem_rdata  input  32  instruction data, returned exactly 1 cycle after the request
- out_valid  output  1  queue head holds a valid instruction
- out_ready  input  1  decode accepts the head this cycle
- out_instr  output  32  head instruction
- out_pc  output  32  PC of head instruction
- redirect_valid  input  1  flush and restart fetch
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored
- busy  output  1  queue non-empty or a request in flight

Behaviour:
- Reset, sampled on posedge while reset=1:
  - fetch_pc=RESET_PC, queue empty, inflight=0.
  - Outputs: out_valid=0, imem_req=0, busy=0, out_instr=0, out_pc=0.
  - Asserting reset mid-operation discards all queued and in-flight instructions.
- Pop: pop = out_valid & out_ready. On pop, the head is removed at the clock edge.
- Issue rule (combinational): imem_req = !reset & !redirect_valid & (count + inflight - pop < DEPTH).
  - On issue: imem_addr=fetch_pc; fetch_pc <= fetch_pc+4, modulo 2^32, so 0xFFFF_FFFC wraps to 0.
  - inflight <= imem_req. At most one request is outstanding, because memory latency is fixed at 1.
- Response capture: in the cycle after an issue, if inflight=1 and no redirect is present, push {issued_pc, imem_rdata} into the queue. issued_pc is the registered copy of imem_addr.
- Push and pop in the same cycle: both take effect and count is unchanged. The issue rule guarantees a push never targets a full queue; asserting on overflow is a bench check, not RTL.
- Latency: request in cycle N, queue write at end of N+1, out_valid=1 in N+2. There is no bypass path.
- Throughput: with out_ready held 1, one instruction per cycle in steady state.
- Output stability: while out_valid=1 and out_ready=0, out_instr and out_pc hold stable and out_valid stays 1.
- Redirect, highest priority after reset, when redirect_valid=1 at a posedge:
  - Queue cleared; inflight cleared.
  - Any response arriving that cycle is dropped.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - Effect on outputs:
    - No request is issued in the redirect cycle.
    - The first request to the new PC goes out the next cycle.
    - out_valid=0 until that fetch returns (2 cycles after the redirect cycle).
    - A pop asserted in the redirect cycle is permitted; decode is responsible for discarding it.
- Redirect held high for multiple cycles: each cycle re-flushes and reloads fetch_pc; fetch resumes the cycle after deassertion.
- busy = (count != 0) | inflight.
- FSM: two states.
  - FILL: queue empty, or refilling after reset or redirect.
  - STREAM: queue non-empty.
  - The state is derivable from count and is kept only for debug visibility; out_valid is driven from count != 0.

Decomposition:
- Shared package cpu_pkg:
  - XLEN=32, ILEN=32, PC_STEP=32'd4
  - typedef fetch_entry_t packed struct {logic [31:0] pc; logic [31:0] instr;}
  - NOP_INSTR=32'h0000_0013
- One sub-module, fetch_fifo:
  - Parameterised circular buffer of fetch_entry_t with DEPTH entries.
  - Signals: push, pop, flush, count, head.
  - Wrap-around uses log2(DEPTH)-bit pointers plus a separate count register.

Test Plan:
- Reset release, memory returns 32'h0000_0013 for PC 0: first low-reset cycle imem_req=1, imem_addr=0; out_valid=1 two cycles later with out_pc=0, out_instr=32'h0000_0013.
- out_ready held 1 for 10 cycles: out_pc sequence 0x0,0x4,...,0x24 on consecutive cycles, no gaps after the first valid, no duplicates.
- out_ready=0 for 6 cycles mid-stream: imem_req drops once count+inflight=DEPTH; head PC stays constant. After release the sequence continues at head PC+4 with no loss.
- redirect_valid pulse with redirect_pc=0x0000_0043 while PC 0x8 is in flight: 0x8 and all queued entries never appear; next out_pc=0x40; imem_addr=0x40 one cycle after the pulse.
- fetch_pc=0xFFFF_FFF8 via redirect, stream 3 instructions: out_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- reset asserted for 1 cycle with 2 queued entries: next cycle out_valid=0, busy=0; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared RV32I core types and constants used by the fetch stage and its bench.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bundle: instruction-memory port, decode handshake and redirect.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [ILEN-1:0] imem_rdata;

  logic            out_valid;
  logic            out_ready;
  logic [ILEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  logic            busy;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, busy,
    input  imem_rdata, out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, busy,
    output imem_rdata, out_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer of fetch entries; count register separates full from empty.
// Push visible at head the cycle after the write; flush empties it in one cycle.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  fetch_entry_t           push_dat_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [$clog2(DEPTH):0] count_o,
  output fetch_entry_t           head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: issues word fetches, queues {pc,instr}, hands them to decode.
// Request-to-out_valid is 2 cycles; issue stalls when queue plus in-flight reaches DEPTH.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] issued_pc_q, issued_pc_d;
  logic            inflight_q, inflight_d;

  logic [CW-1:0]   fifo_count;
  logic [CW-1:0]   occupancy;
  logic [CW-1:0]   count_nxt;
  fetch_entry_t    fifo_head;
  fetch_entry_t    push_entry;
  logic            has_entry;
  logic            pop;
  logic            push;
  logic            issue;

  assign has_entry = (fifo_count != '0);
  assign pop       = has_entry & bus.out_ready;

  // Slots already promised to the queue after this cycle's pop; the single
  // in-flight response is counted so a push can never land on a full queue.
  assign occupancy = fifo_count + CW'(inflight_q) - CW'(pop);
  assign issue     = !reset && !bus.redirect_valid && (occupancy < CW'(DEPTH));
  assign push      = inflight_q && !bus.redirect_valid && !reset;

  assign push_entry = '{pc: issued_pc_q, instr: bus.imem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_dat_i (push_entry),
    .pop_i      (pop),
    .flush_i    (bus.redirect_valid),
    .count_o    (fifo_count),
    .head_o     (fifo_head)
  );

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    inflight_d  = issue;
    if (bus.redirect_valid) begin
      fetch_pc_d = align_pc(bus.redirect_pc);
    end else if (issue) begin
      fetch_pc_d  = fetch_pc_q + PC_STEP;
      issued_pc_d = fetch_pc_q;
    end
  end

  always_comb begin
    count_nxt = fifo_count;
    if (push) count_nxt = count_nxt + CW'(1);
    if (pop)  count_nxt = count_nxt - CW'(1);

    state_d = state_q;
    unique case (state_q)
      FILL:    if (count_nxt != '0) state_d = STREAM;
      STREAM:  if (count_nxt == '0) state_d = FILL;
      default: state_d = FILL;
    endcase
    if (bus.redirect_valid) state_d = FILL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
      inflight_q  <= inflight_d;
    end
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = has_entry;
  assign bus.out_instr = has_entry ? fifo_head.instr : '0;
  assign bus.out_pc    = has_entry ? fifo_head.pc : '0;
  assign bus.busy      = has_entry | inflight_q;

endmodule
